// File: rtl/joybus_pkg.sv
// Shared Joybus transmitter definitions: stop kinds, per-cell level masks and FSM states.
package joybus_pkg;

  localparam logic STOP_CONSOLE    = 1'b0;
  localparam logic STOP_CONTROLLER = 1'b1;

  // Level masks, MSB is the first level on the wire, 1 means pull the line low
  localparam logic [3:0] MASK_BIT0            = 4'b1110;
  localparam logic [3:0] MASK_BIT1            = 4'b1000;
  localparam logic [3:0] MASK_STOP_CONSOLE    = 4'b1000;
  localparam logic [3:0] MASK_STOP_CONTROLLER = 4'b1100;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_DATA = 2'd1,
    ST_STOP = 2'd2
  } tx_state_t;

  // Picks the 4-level pattern for a data cell or for the stop cell
  function automatic logic [3:0] cell_mask(input logic is_stop, input logic value);
    if (is_stop) begin
      return (value == STOP_CONTROLLER) ? MASK_STOP_CONTROLLER : MASK_STOP_CONSOLE;
    end
    return value ? MASK_BIT1 : MASK_BIT0;
  endfunction

endpackage

// File: rtl/n_bit_counter.sv
// Free-running up counter with synchronous clear and enable.
module n_bit_counter #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             clear,
  input  logic             enable,
  output logic [WIDTH-1:0] count
);

  // Clear has priority over counting so the owner can restart a period on any cycle
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      count <= '0;
    end else if (clear) begin
      count <= '0;
    end else if (enable) begin
      count <= count + WIDTH'(1);
    end
  end

endmodule

// File: rtl/joybus_tx.sv
// Joybus serial transmitter: turns a latched byte frame plus stop cell into open-drain level cells.
module joybus_tx
  import joybus_pkg::*;
#(
  parameter int LEVEL_WIDTH = 2,
  parameter int MAX_BYTES   = 4,
  parameter int CNT_W       = $clog2(MAX_BYTES + 1)
) (
  input  logic                   clk,
  input  logic                   reset_n,
  input  logic                   start,
  input  logic [CNT_W-1:0]       byte_count,
  input  logic [8*MAX_BYTES-1:0] tx_data,
  input  logic                   stop_kind,
  input  logic                   abort,
  output logic                   drive_low,
  output logic                   busy,
  output logic                   done,
  output logic                   err
);

  localparam int LVL_W  = (LEVEL_WIDTH > 1) ? $clog2(LEVEL_WIDTH) : 1;
  localparam int DATA_W = 8 * MAX_BYTES;

  tx_state_t           state_q, state_d;
  logic [1:0]          lvl_idx_q, lvl_idx_d;
  logic [2:0]          bit_idx_q, bit_idx_d;
  logic [CNT_W-1:0]    byte_idx_q, byte_idx_d;
  logic [CNT_W-1:0]    count_q, count_d;
  logic                stop_q, stop_d;
  logic [DATA_W-1:0]   shift_q, shift_d;
  logic [3:0]          mask_d;
  logic                drive_low_d, busy_d, done_d, err_d;
  logic [LVL_W-1:0]    level_cnt;
  logic                level_end, cell_end, count_ok, accept, level_clear;

  assign count_ok    = (byte_count != '0) && (byte_count <= CNT_W'(MAX_BYTES));
  assign accept      = (state_q == ST_IDLE) && start && count_ok;
  assign level_end   = (level_cnt == LVL_W'(LEVEL_WIDTH - 1));
  assign cell_end    = level_end && (lvl_idx_q == 2'd3);
  assign level_clear = (state_q == ST_IDLE) || accept || abort || level_end;

  n_bit_counter #(
    .WIDTH (LVL_W)
  ) u_level_cnt (
    .clk     (clk),
    .reset_n (reset_n),
    .clear   (level_clear),
    .enable  (1'b1),
    .count   (level_cnt)
  );

  // Next-state logic: walks level -> bit -> byte, then the stop cell, and precomputes the next line level
  always_comb begin
    state_d    = state_q;
    lvl_idx_d  = lvl_idx_q;
    bit_idx_d  = bit_idx_q;
    byte_idx_d = byte_idx_q;
    count_d    = count_q;
    stop_d     = stop_q;
    shift_d    = shift_q;
    done_d     = 1'b0;
    err_d      = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (start) begin
          if (count_ok) begin
            state_d    = ST_DATA;
            lvl_idx_d  = 2'd0;
            bit_idx_d  = 3'd7;
            byte_idx_d = '0;
            count_d    = byte_count;
            stop_d     = stop_kind;
            shift_d    = tx_data;
          end else begin
            err_d = 1'b1;
          end
        end
      end

      ST_DATA: begin
        if (abort) begin
          state_d    = ST_IDLE;
          lvl_idx_d  = 2'd0;
          bit_idx_d  = 3'd0;
          byte_idx_d = '0;
        end else if (level_end) begin
          lvl_idx_d = lvl_idx_q + 2'd1;
          if (cell_end) begin
            bit_idx_d = bit_idx_q - 3'd1;
            shift_d   = shift_q << 1;
            if (bit_idx_q == 3'd0) begin
              if (byte_idx_q == count_q - CNT_W'(1)) begin
                state_d    = ST_STOP;
                byte_idx_d = '0;
                bit_idx_d  = 3'd0;
              end else begin
                byte_idx_d = byte_idx_q + CNT_W'(1);
              end
            end
          end
        end
      end

      ST_STOP: begin
        if (abort) begin
          state_d   = ST_IDLE;
          lvl_idx_d = 2'd0;
        end else if (level_end) begin
          lvl_idx_d = lvl_idx_q + 2'd1;
          if (cell_end) begin
            state_d = ST_IDLE;
            done_d  = 1'b1;
          end
        end
      end

      default: begin
        state_d    = ST_IDLE;
        lvl_idx_d  = 2'd0;
        bit_idx_d  = 3'd0;
        byte_idx_d = '0;
      end
    endcase

    mask_d      = cell_mask(state_d == ST_STOP,
                            (state_d == ST_STOP) ? stop_d : shift_d[DATA_W-1]);
    busy_d      = (state_d != ST_IDLE);
    drive_low_d = busy_d && mask_d[2'd3 - lvl_idx_d];
  end

  // State, counters, latched frame and registered outputs; reset releases the line at once
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= ST_IDLE;
      lvl_idx_q  <= 2'd0;
      bit_idx_q  <= 3'd0;
      byte_idx_q <= '0;
      count_q    <= '0;
      stop_q     <= 1'b0;
      shift_q    <= '0;
      drive_low  <= 1'b0;
      busy       <= 1'b0;
      done       <= 1'b0;
      err        <= 1'b0;
    end else begin
      state_q    <= state_d;
      lvl_idx_q  <= lvl_idx_d;
      bit_idx_q  <= bit_idx_d;
      byte_idx_q <= byte_idx_d;
      count_q    <= count_d;
      stop_q     <= stop_d;
      shift_q    <= shift_d;
      drive_low  <= drive_low_d;
      busy       <= busy_d;
      done       <= done_d;
      err        <= err_d;
    end
  end

endmodule

// File: tb/tb_joybus_tx.sv
// Self-checking bench for joybus_tx: per-cycle scoreboard of busy/drive_low/done/err.
module tb_joybus_tx;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        start_a, start_b;
  logic [2:0]  byte_count;
  logic [31:0] tx_data;
  logic        stop_kind;
  logic        abort;
  logic        dl_a, busy_a, done_a, err_a;
  logic        dl_b, busy_b, done_b, err_b;

  typedef struct packed {
    logic busy;
    logic dl;
    logic done;
    logic err;
  } exp_t;

  typedef struct {
    int          inst;
    int          n;
    logic [31:0] data;
    logic        stop;
    int          exp_len;
  } vec_t;

  exp_t qa[$];
  exp_t qb[$];
  int   checks = 0;
  int   errors = 0;

  // 10 ns clock
  always #5 clk = ~clk;

  joybus_tx #(.LEVEL_WIDTH(2), .MAX_BYTES(4)) dut_a (
    .clk(clk), .reset_n(reset_n), .start(start_a), .byte_count(byte_count),
    .tx_data(tx_data), .stop_kind(stop_kind), .abort(abort),
    .drive_low(dl_a), .busy(busy_a), .done(done_a), .err(err_a)
  );

  joybus_tx #(.LEVEL_WIDTH(1), .MAX_BYTES(4)) dut_b (
    .clk(clk), .reset_n(reset_n), .start(start_b), .byte_count(byte_count),
    .tx_data(tx_data), .stop_kind(stop_kind), .abort(abort),
    .drive_low(dl_b), .busy(busy_b), .done(done_b), .err(err_b)
  );

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s got %0d expected %0d at %0t", name, actual, expected, $time);
    end
  endtask

  task automatic pushExp(input int which, input exp_t e);
    if (which == 0) qa.push_back(e);
    else            qb.push_back(e);
  endtask

  // Expected per-cycle trace from the bit-cell definitions; cut>=0 truncates for an abort at cycle cut-1
  task automatic pushFrame(input int which, input int lw, input int n, input logic [31:0] data,
                           input logic stop, input int cut);
    logic [31:0] d;
    logic        bitv;
    logic        low;
    int          cyc;
    d   = data;
    cyc = 0;
    for (int b = 0; b < n; b++) begin
      for (int i = 0; i < 8; i++) begin
        bitv = d[31];
        d    = d << 1;
        for (int l = 0; l < 4; l++) begin
          low = (l == 0) || (!bitv && l < 3);
          for (int c = 0; c < lw; c++) begin
            if (cut < 0 || cyc < cut) pushExp(which, '{busy: 1'b1, dl: low, done: 1'b0, err: 1'b0});
            cyc++;
          end
        end
      end
    end
    for (int l = 0; l < 4; l++) begin
      low = (l == 0) || (stop && l == 1);
      for (int c = 0; c < lw; c++) begin
        if (cut < 0 || cyc < cut) pushExp(which, '{busy: 1'b1, dl: low, done: 1'b0, err: 1'b0});
        cyc++;
      end
    end
    if (cut < 0) begin
      pushExp(which, '{busy: 1'b0, dl: 1'b0, done: 1'b1, err: 1'b0});
    end else begin
      pushExp(which, '{busy: 1'b0, dl: 1'b0, done: 1'b0, err: 1'b0});
      pushExp(which, '{busy: 1'b0, dl: 1'b0, done: 1'b0, err: 1'b0});
    end
  endtask

  // Drives one start request; returns 1 ns after the accept edge with the expected trace queued
  task automatic applyStimulus(input int which, input int n, input logic [31:0] data,
                               input logic stop, input int cut);
    byte_count = 3'(n);
    tx_data    = data;
    stop_kind  = stop;
    if (which == 0) start_a = 1'b1;
    else            start_b = 1'b1;
    @(posedge clk);
    pushFrame(which, (which == 0) ? 2 : 1, n, data, stop, cut);
    #1;
    start_a = 1'b0;
    start_b = 1'b0;
  endtask

  task automatic waitDrain(input int max_cycles);
    int k;
    k = 0;
    @(posedge clk);
    while ((qa.size() > 0 || qb.size() > 0) && k < max_cycles) begin
      @(posedge clk);
      k++;
    end
    if (qa.size() > 0 || qb.size() > 0) begin
      checkOutput("drain_timeout", 32'd1, 32'd0);
      qa.delete();
      qb.delete();
    end
    #1;
  endtask

  // Counts frame cycles from the accept edge until done, bounded
  task automatic measureFrame(input int which, input int exp_len);
    int   k;
    logic found;
    found = 1'b0;
    for (k = 0; k < exp_len + 20; k++) begin
      @(negedge clk);
      if ((which == 0) ? done_a : done_b) begin
        found = 1'b1;
        break;
      end
    end
    checkOutput("frame_len", found ? 32'(k) : 32'hFFFF_FFFF, 32'(exp_len));
  endtask

  // Scoreboard: pop one expected entry per instance per cycle, sampled on the falling edge
  always @(negedge clk) begin
    exp_t e;
    if (qa.size() > 0) begin
      e = qa.pop_front();
      checkOutput("a_busy", 32'(busy_a), 32'(e.busy));
      checkOutput("a_drive_low", 32'(dl_a), 32'(e.dl));
      checkOutput("a_done", 32'(done_a), 32'(e.done));
      checkOutput("a_err", 32'(err_a), 32'(e.err));
    end
    if (qb.size() > 0) begin
      e = qb.pop_front();
      checkOutput("b_busy", 32'(busy_b), 32'(e.busy));
      checkOutput("b_drive_low", 32'(dl_b), 32'(e.dl));
      checkOutput("b_done", 32'(done_b), 32'(e.done));
      checkOutput("b_err", 32'(err_b), 32'(e.err));
    end
  end

  initial begin
    #300000;
    $display("[TB] FAIL watchdog expired at %0t", $time);
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    vec_t tbl[5];
    tbl[0] = '{inst: 0, n: 3, data: 32'h0500_00C3, stop: 1'b1, exp_len: 200};
    tbl[1] = '{inst: 1, n: 4, data: 32'hFFFF_FFFF, stop: 1'b0, exp_len: 132};
    tbl[2] = '{inst: 0, n: 1, data: 32'h9A00_0000, stop: 1'b0, exp_len: 72};
    tbl[3] = '{inst: 1, n: 2, data: 32'h3C5A_0000, stop: 1'b1, exp_len: 68};
    tbl[4] = '{inst: 0, n: 4, data: 32'h1234_5678, stop: 1'b1, exp_len: 264};

    reset_n    = 1'b0;
    start_a    = 1'b0;
    start_b    = 1'b0;
    byte_count = 3'd0;
    tx_data    = 32'd0;
    stop_kind  = 1'b0;
    abort      = 1'b0;
    #1;
    checkOutput("rst_a_drive_low", 32'(dl_a), 32'd0);
    checkOutput("rst_a_busy", 32'(busy_a), 32'd0);
    checkOutput("rst_a_done", 32'(done_a), 32'd0);
    checkOutput("rst_a_err", 32'(err_a), 32'd0);
    checkOutput("rst_b_drive_low", 32'(dl_b), 32'd0);
    checkOutput("rst_b_busy", 32'(busy_b), 32'd0);
    repeat (2) @(posedge clk);
    #1 reset_n = 1'b1;
    @(posedge clk);
    #1;

    $display("[TB] table-driven frames");
    for (int i = 0; i < 5; i++) begin
      applyStimulus(tbl[i].inst, tbl[i].n, tbl[i].data, tbl[i].stop, -1);
      measureFrame(tbl[i].inst, tbl[i].exp_len);
      waitDrain(400);
    end

    $display("[TB] rejected starts");
    applyStimulus(0, 0, 32'hFFFF_FFFF, 1'b0, -1);
    qa.delete();
    qa.push_back('{busy: 1'b0, dl: 1'b0, done: 1'b0, err: 1'b1});
    qa.push_back('{busy: 1'b0, dl: 1'b0, done: 1'b0, err: 1'b0});
    waitDrain(10);
    applyStimulus(1, 5, 32'hFFFF_FFFF, 1'b1, -1);
    qb.delete();
    qb.push_back('{busy: 1'b0, dl: 1'b0, done: 1'b0, err: 1'b1});
    qb.push_back('{busy: 1'b0, dl: 1'b0, done: 1'b0, err: 1'b0});
    waitDrain(10);

    $display("[TB] abort at frame cycle 37 then restart");
    applyStimulus(0, 3, 32'hA5C3_0F00, 1'b0, 38);
    repeat (37) @(posedge clk);
    #1 abort = 1'b1;
    @(posedge clk);
    #1 abort = 1'b0;
    @(posedge clk);
    #1;
    applyStimulus(0, 2, 32'h6E91_0000, 1'b1, -1);
    measureFrame(0, 136);
    waitDrain(300);

    $display("[TB] starts while busy are ignored");
    applyStimulus(0, 2, 32'hC35A_0000, 1'b0, -1);
    for (int i = 0; i < 20; i++) begin
      @(posedge clk);
      #1;
      start_a    = 1'b1;
      tx_data    = $urandom;
      byte_count = 3'($urandom_range(0, 7));
      stop_kind  = ~stop_kind;
    end
    @(posedge clk);
    #1 start_a = 1'b0;
    waitDrain(300);

    $display("[TB] back-to-back frames");
    applyStimulus(1, 1, 32'hA000_0000, 1'b0, -1);
    repeat (36) @(posedge clk);
    #1;
    applyStimulus(1, 1, 32'h5B00_0000, 1'b1, -1);
    waitDrain(100);

    $display("[TB] asynchronous reset mid-frame");
    byte_count = 3'd1;
    tx_data    = 32'h0000_0000;
    stop_kind  = 1'b0;
    start_a    = 1'b1;
    @(posedge clk);
    #1 start_a = 1'b0;
    #2;
    checkOutput("pre_rst_drive_low", 32'(dl_a), 32'd1);
    reset_n = 1'b0;
    #1;
    checkOutput("async_rst_drive_low", 32'(dl_a), 32'd0);
    checkOutput("async_rst_busy", 32'(busy_a), 32'd0);
    @(posedge clk);
    #1 reset_n = 1'b1;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      checkOutput("post_rst_busy", 32'(busy_a), 32'd0);
      checkOutput("post_rst_drive_low", 32'(dl_a), 32'd0);
      checkOutput("post_rst_done", 32'(done_a), 32'd0);
    end
    @(posedge clk);
    #1;
    applyStimulus(0, 1, 32'h8100_0000, 1'b1, -1);
    waitDrain(100);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/joybus_tx.md
# joybus_tx

Parametrised Joybus (N64 controller protocol) serial transmitter. It takes a frame of 1..MAX_BYTES bytes plus a stop-bit kind and emits them as 4-level Joybus bit cells on an open-drain line. It is the TX half of the fake N64 controller, and it also serves any console-side master we build. The line is never driven high: the block only pulls low or releases, and an external pull-up provides HIGH.

## Interface
- LEVEL_WIDTH, 2: clk cycles per level; must be ≥1.
- MAX_BYTES, 4: maximum payload bytes per frame; must be ≥1.
- CNT_W, $clog2(MAX_BYTES+1): width of byte_count (derived; do not override).
- clk  in  1  single clock; all logic is on the rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- start  in  1  frame request; sampled only in IDLE.
- byte_count  in  CNT_W  number of payload bytes, captured on accept.
- tx_data  in  8*MAX_BYTES  payload, captured on accept. Byte 0 is tx_data[8*MAX_BYTES-1 -: 8].
- stop_kind  in  1  0 = console stop (L,H,H,Z); 1 = controller stop (L,L,H,Z). Captured on accept.
- abort  in  1  synchronous cancel of the frame in progress.
- drive_low  out  1  1 = pull line low; 0 = release. Registered.
- busy  out  1  high while a frame is on the wire.
- done  out  1  one-cycle pulse when a frame completes normally.
- err  out  1  one-cycle pulse when a start is rejected.

## Operation
- Reset values: drive_low=0, busy=0, done=0, err=0, state=IDLE, all counters 0.
- FSM states: IDLE, DATA, STOP.
- IDLE → DATA requires start=1 and 1 ≤ byte_count ≤ MAX_BYTES.
  - On accept, tx_data, byte_count and stop_kind are latched into internal registers.
  - Later changes on these inputs have no effect on the current frame.
- start with byte_count=0 or byte_count>MAX_BYTES: the FSM stays in IDLE and err pulses the next cycle.
- start while busy is ignored: no err, no effect.
- Bit order: byte 0 first; MSB first within each byte.
- Each bit is a cell of 4 levels, each level LEVEL_WIDTH cycles long.
  - Logical 0 = L,L,L,H.
  - Logical 1 = L,H,H,H.
  - L means drive_low=1; H and Z mean drive_low=0.
- DATA → STOP after the last level of bit 0 of the final byte.
- STOP emits one 4-level cell according to the latched stop_kind. Its 4th level is Z, which is still timed for LEVEL_WIDTH cycles.
- STOP → IDLE after that level; done pulses.
- Counters:
  - level_cnt counts 0..LEVEL_WIDTH-1.
  - lvl_idx counts 0..3.
  - bit_idx counts 7..0.
  - byte_idx counts 0..count-1.
  - Each counter wraps to its start value and carries into the next counter.
- abort in DATA or STOP:
  - Next cycle: state=IDLE, drive_low=0, busy=0.
  - No done and no err.
- abort in IDLE is ignored. If abort and start are both high in IDLE, start is processed normally.
- Reset mid-frame: drive_low is released immediately (asynchronously) and all state clears.

## Timing
- Accept edge = the rising edge at which start=1 is sampled in IDLE.
- The first cycle after the accept edge is frame cycle 0.
  - busy=1 and drive_low carries the first L level.
- Frame length F = (8·N + 1)·4·LEVEL_WIDTH cycles, where N = latched byte_count.
- busy is high for exactly frame cycles 0..F-1.
- done=1 on cycle F. On that cycle busy=0 and drive_low=0.
- A new start sampled on cycle F is accepted, so back-to-back frames have 1 idle cycle between them.
- err fires on the cycle after a rejected start.
- There is no combinational path from any input to any output.

## Structure
- Package joybus_pkg holds:
  - STOP_CONSOLE=1'b0 and STOP_CONTROLLER=1'b1.
  - 4-bit level masks, MSB = first level, 1 = drive low: BIT0=4'b1110, BIT1=4'b1000, STOP_CONSOLE=4'b1000, STOP_CONTROLLER=4'b1100.
  - FSM state encodings.
- drive_low is the registered value of mask[3-lvl_idx].
- The level counter reuses the existing n_bit_counter sub-module. Its reset is driven at level boundaries, abort and accept.
- The other counters and the FSM are local to the block.

## Test plan
- LEVEL_WIDTH=2, N=3, tx_data=0x050000xx, controller stop → busy for 200 cycles.
  - drive_low per 8-cycle cell follows 0000_0101 0000_0000 0000_0000, then stop pattern 1,1,1,1,0,0,0,0.
  - done pulses on cycle 200.
- LEVEL_WIDTH=1, N=4, 0xFFFFFFFF, console stop → 132 cycles, every cell 1,0,0,0; done on cycle 132.
- start with byte_count=0, then with byte_count=5 (MAX_BYTES=4) → err pulse each time; busy and drive_low stay 0.
- Mid-frame (cycle 37): assert abort → next cycle busy=0 and drive_low=0, no done. A start 2 cycles later sends a full, correct frame.
- Mid-frame: pulse start with different data every cycle → ignored; the transmitted bits match the data latched at accept.
- Mid-frame reset_n low in the middle of a cycle → drive_low drops to 0 asynchronously. All outputs hold reset values until the first start after reset release.
